// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and helpers for the UART receive front-end.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Clocks per bit, truncated.
  function automatic int calc_cpb(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Read-side bus between the receiver FIFO and its consumer (dma).
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 16
) ();
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic             rd_en;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic [CNT_W-1:0] count;
  logic             frame_err;
  logic             overrun;
  logic             clr_err;

  // consumer side
  modport master (
    output rd_en, clr_err,
    input  rd_data, rd_valid, count, frame_err, overrun
  );

  // receiver side
  modport slave (
    input  rd_en, clr_err,
    output rd_data, rd_valid, count, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_fifo_fifo.sv
// First-word-fall-through FIFO; head entry always visible on rd_data.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop_req,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       drop
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             empty, full, do_pop, do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop_req && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr];
  assign count    = cnt;

  // storage write, no reset needed: entries are only read when valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // pointers and occupancy; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with centre sampling, FWFT byte FIFO and sticky errors.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           uartRx,
  uart_rx_fifo_if.slave  bus
);
  import uart_pkg::*;

  localparam int CPB  = calc_cpb(CLK_HZ, BAUD);
  localparam int HALF = CPB / 2;
  localparam int BW   = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  logic sync1, rx_s, rx_prev;
  logic [1:0] flush_cnt;
  logic armed;

  state_t state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic push, ferr_set, tick;

  logic          drop;
  logic [CW-1:0] fifo_cnt;

  // two-flop synchroniser plus edge history; flops idle high
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= uartRx;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  // After reset the synchroniser holds fake 1s for two clocks; only arm
  // edge detection once the real line has been seen high, so a line
  // still low (break) at reset release cannot start a frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flush_cnt <= '0;
      armed     <= 1'b0;
    end else begin
      if (flush_cnt != 2'd2) flush_cnt <= flush_cnt + 2'd1;
      if (flush_cnt == 2'd2 && rx_s) armed <= 1'b1;
    end
  end

  // receiver state and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign tick = (baud_q == '0);

  // next-state: half a bit to the start centre, then a full bit per sample
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed && rx_prev && !rx_s) begin
          state_d = START;
          baud_d  = BW'(HALF - 1);
        end
      end
      START: begin
        if (!tick) begin
          baud_d = baud_q - BW'(1);
        end else if (!rx_s) begin
          state_d = DATA;
          baud_d  = BW'(CPB - 1);
          bit_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!tick) begin
          baud_d = baud_q - BW'(1);
        end else begin
          shift_d[bit_q] = rx_s;
          baud_d         = BW'(CPB - 1);
          if (bit_q == 3'(DATA_BITS - 1)) state_d = STOP;
          else                            bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (!tick) begin
          baud_d = baud_q - BW'(1);
        end else begin
          state_d = IDLE;
          if (rx_s) push     = 1'b1;
          else      ferr_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  sync_fifo_fwft #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (shift_q),
    .pop_req   (bus.rd_en),
    .rd_data   (bus.rd_data),
    .rd_valid  (bus.rd_valid),
    .count     (fifo_cnt),
    .drop      (drop)
  );

  assign bus.count = fifo_cnt;

  // sticky flags; a new event in the clearing cycle wins
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.frame_err <= ferr_set | (bus.frame_err & ~bus.clr_err);
      bus.overrun   <= drop     | (bus.overrun   & ~bus.clr_err);
    end
  end
endmodule
